irq_vector_dispatch: RTL and testbench
======================================

Name: irq_vector_dispatch

Overview:
- Sequential back end for the 27-channel (3 groups x 9 channels) combinational priority interrupt decoder.
- Consumes the decoder's group-request flags and encoded channel index, filters them until stable, and forms a 5-bit flat vector.
- Presents the vector to the CPU with an irq/ack/eoi handshake and tracks the in-service group.

Parameters:
- SETTLE_CYC, 2, consecutive identical samples required before presenting (>=1).
- TIMEOUT_CYC, 64, PRESENT cycles allowed without ack; 0 disables the timeout.
- CNT_W, 7, width of the shared settle/timeout counter; must hold max(SETTLE_CYC, TIMEOUT_CYC).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- grp_req  in  3  active-high group request flags; bit0=A (highest priority), bit1=B, bit2=C.
- chan_idx  in  4  encoded winning channel within the highest requesting group; legal values 0..8.
- irq  out  1  interrupt request to CPU.
- irq_vec  out  5  flat vector, 0..26.
- irq_ack  in  1  CPU acknowledge, single-cycle pulse.
- irq_eoi  in  1  CPU end-of-interrupt pulse.
- in_service  out  3  one-hot group currently in service.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky; no ack within TIMEOUT_CYC.
- err_badidx  out  1  sticky; chan_idx>8 at latch.
- err_clr  in  1  clears both sticky errors.

Behaviour:
- Reset: synchronous, active-high. State=IDLE. irq=0, irq_vec=0, in_service=0, busy=0, err_*=0, counter=0, snapshot=0. Reset aborts any state immediately, including mid-PRESENT and mid-SERVICE.
- Group select: g = index of the lowest set bit of grp_req (A=0, B=1, C=2).
- Vector arithmetic: irq_vec = 9*g + chan_idx, computed as (g<<3)+g+chan. Result is 5 bits, no overflow for legal inputs.
- IDLE:
  - grp_req!=0 -> SETTLE; snapshot {grp_req, chan_idx}; cnt=0.
- SETTLE:
  - grp_req==0 -> IDLE.
  - Inputs differ from snapshot -> reload snapshot; cnt=0; stay.
  - Inputs equal and cnt<SETTLE_CYC-1 -> cnt++.
  - Inputs equal and cnt==SETTLE_CYC-1, with snapshot chan<=8 -> latch irq_vec, record g, go PRESENT, cnt=0.
  - Inputs equal and cnt==SETTLE_CYC-1, with chan>8 -> set err_badidx, go IDLE, nothing presented.
- Latency: request stable from cycle N gives irq=1 in cycle N+SETTLE_CYC+1.
- PRESENT:
  - irq=1; irq_vec held constant; input changes are ignored.
  - irq_ack=1 -> SERVICE next cycle; irq=0; in_service = 1<<g.
  - No ack and TIMEOUT_CYC!=0: cnt++. On cnt==TIMEOUT_CYC-1 without ack -> err_timeout=1, irq=0, IDLE.
  - Ack arriving in the final timeout cycle: the ack wins, no error.
- SERVICE:
  - irq=0.
  - irq_eoi=1 -> IDLE; in_service=0 next cycle.
  - Group requests during SERVICE are not accepted.
- Ignored pulses:
  - irq_ack outside PRESENT.
  - irq_eoi outside SERVICE.
  - ack and eoi together in PRESENT: ack taken, eoi dropped.
- Minimum of one IDLE cycle between successive dispatches.
- irq_vec retains its last latched value outside PRESENT.
- err_clr: clears both sticky flags. A set condition in the same cycle wins, so the flag stays 1.

Optional Feature:
- Macro: IRQ_DISPATCH_STATS_EN.
- When defined, adds outputs stat_a, stat_b, stat_c (16 bits each): per-group counts of accepted acks.
  - Each counter increments on the PRESENT->SERVICE transition for group g.
  - Counters saturate at 16'hFFFF, reset to 0, and are unaffected by err_clr.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- SETTLE_CYC=2, grp_req=3'b010, chan_idx=4 held from cycle 5 -> irq=1 at cycle 8, irq_vec=13. Ack at cycle 10 -> irq=0, in_service=3'b010 at cycle 11. Eoi at cycle 14 -> in_service=0, busy=0 at cycle 15.
- grp_req=3'b101, chan_idx=8 stable -> irq_vec=8 (group A wins). Then grp_req=3'b100, chan_idx=8 -> irq_vec=26.
- chan_idx toggles 3/5 every cycle with grp_req=3'b001 for 10 cycles -> irq stays 0. Hold at 5 -> irq rises 3 cycles later with irq_vec=5.
- TIMEOUT_CYC=64, no ack -> err_timeout=1 and irq=0 after 64 PRESENT cycles; state returns to IDLE. Assert err_clr -> err_timeout=0 next cycle.
- chan_idx=4'd12 stable with grp_req=3'b001 -> err_badidx=1, irq never asserted.
- Reset mid-SERVICE -> all outputs at reset values next cycle. With IRQ_DISPATCH_STATS_EN, 3 group-C acks -> stat_c=3; a preloaded 16'hFFFF stays 16'hFFFF after a further ack.

Source files
------------

// File: rtl/irq_vector_dispatch.sv
// Sequential back end for the 3x9 priority interrupt decoder: settle filter, vector latch, irq/ack/eoi handshake.
// Optional per-group ack statistics are built when IRQ_DISPATCH_STATS_EN is defined.
module irq_vector_dispatch #(
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  grp_req,
    input  logic [3:0]  chan_idx,
    output logic        irq,
    output logic [4:0]  irq_vec,
    input  logic        irq_ack,
    input  logic        irq_eoi,
    output logic [2:0]  in_service,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_badidx,
    input  logic        err_clr
`ifdef IRQ_DISPATCH_STATS_EN
    ,
    output logic [15:0] stat_a,
    output logic [15:0] stat_b,
    output logic [15:0] stat_c
`endif
);

    // state   | meaning
    // IDLE    | no request pending
    // SETTLE  | request seen, waiting for SETTLE_CYC identical samples
    // PRESENT | irq high with latched vector, waiting for ack or timeout
    // SERVICE | ack taken, group in service until eoi
    typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, SERVICE} state_t;

    localparam int TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TO_LAST_I);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       snap_grp_q, snap_grp_d;
    logic [3:0]       snap_chan_q, snap_chan_d;
    logic [1:0]       grp_q, grp_d;
    logic [4:0]       vec_q, vec_d;
    logic             err_to_q, err_to_d;
    logic             err_bad_q, err_bad_d;
    logic             set_to, set_bad, ack_take;
    logic [1:0]       snap_g;

    function automatic logic [1:0] sel_grp(input logic [2:0] req);
        if (req[0])      return 2'd0;
        else if (req[1]) return 2'd1;
        else             return 2'd2;
    endfunction

    // 9*g + chan as (g<<3) + g + chan
    function automatic logic [4:0] flat_vec(input logic [1:0] g, input logic [3:0] chan);
        return {g, 3'b000} + {3'b000, g} + {1'b0, chan};
    endfunction

    assign snap_g = sel_grp(snap_grp_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_grp_d  = snap_grp_q;
        snap_chan_d = snap_chan_q;
        grp_d       = grp_q;
        vec_d       = vec_q;
        set_to      = 1'b0;
        set_bad     = 1'b0;
        ack_take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grp_req != 3'b000) begin
                    state_d     = SETTLE;
                    snap_grp_d  = grp_req;
                    snap_chan_d = chan_idx;
                    cnt_d       = '0;
                end
            end
            SETTLE: begin
                if (grp_req == 3'b000) begin
                    state_d = IDLE;
                end else if ({grp_req, chan_idx} != {snap_grp_q, snap_chan_q}) begin
                    snap_grp_d  = grp_req;
                    snap_chan_d = chan_idx;
                    cnt_d       = '0;
                end else if (cnt_q < SETTLE_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (snap_chan_q <= 4'd8) begin
                    vec_d   = flat_vec(snap_g, snap_chan_q);
                    grp_d   = snap_g;
                    state_d = PRESENT;
                    cnt_d   = '0;
                end else begin
                    set_bad = 1'b1;
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    ack_take = 1'b1;
                    state_d  = SERVICE;
                    cnt_d    = '0;
                end else if (TIMEOUT_CYC != 0) begin
                    if (cnt_q == TO_LAST) begin
                        set_to  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SERVICE: begin
                if (irq_eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a set in the same cycle as err_clr keeps the flag high
        err_to_d  = set_to  | (err_to_q  & ~err_clr);
        err_bad_d = set_bad | (err_bad_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            snap_grp_q  <= '0;
            snap_chan_q <= '0;
            grp_q       <= '0;
            vec_q       <= '0;
            err_to_q    <= 1'b0;
            err_bad_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_grp_q  <= snap_grp_d;
            snap_chan_q <= snap_chan_d;
            grp_q       <= grp_d;
            vec_q       <= vec_d;
            err_to_q    <= err_to_d;
            err_bad_q   <= err_bad_d;
        end
    end

    assign irq         = (state_q == PRESENT);
    assign busy        = (state_q != IDLE);
    assign irq_vec     = vec_q;
    assign in_service  = (state_q == SERVICE) ? (3'b001 << grp_q) : 3'b000;
    assign err_timeout = err_to_q;
    assign err_badidx  = err_bad_q;

`ifdef IRQ_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_a <= '0;
            stat_b <= '0;
            stat_c <= '0;
        end else if (ack_take) begin
            case (grp_q)
                2'd0:    if (stat_a != 16'hFFFF) stat_a <= stat_a + 16'd1;
                2'd1:    if (stat_b != 16'hFFFF) stat_b <= stat_b + 16'd1;
                default: if (stat_c != 16'hFFFF) stat_c <= stat_c + 16'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_irq_vector_dispatch.sv
// Bench for irq_vector_dispatch: directed literal checks plus randomized traffic against a run-length reference model.
module tb_irq_vector_dispatch;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] grp_req = 3'b000;
    logic [3:0] chan_idx = 4'd0;
    logic       irq_ack = 1'b0, irq_eoi = 1'b0, err_clr = 1'b0;
    logic       irq, busy, err_timeout, err_badidx;
    logic [4:0] irq_vec;
    logic [2:0] in_service;
`ifdef IRQ_DISPATCH_STATS_EN
    logic [15:0] stat_a, stat_b, stat_c;
`endif

    int errors = 0;
    int checks = 0;

    irq_vector_dispatch #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .grp_req(grp_req), .chan_idx(chan_idx),
        .irq(irq), .irq_vec(irq_vec), .irq_ack(irq_ack), .irq_eoi(irq_eoi),
        .in_service(in_service), .busy(busy), .err_timeout(err_timeout),
        .err_badidx(err_badidx), .err_clr(err_clr)
`ifdef IRQ_DISPATCH_STATS_EN
        , .stat_a(stat_a), .stat_b(stat_b), .stat_c(stat_c)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: phase 0 waiting, 1 filtering, 2 presenting, 3 servicing.
    // The filter counts a run of identical samples; the first sample taken while waiting counts as one.
    int         m_phase = 0, m_run = 0, m_age = 0, m_g = 0, m_vec = 0;
    int         m_stat[3];
    logic [2:0] m_lastg = 3'b000;
    logic [3:0] m_lastc = 4'd0;
    bit         m_eto = 0, m_ebad = 0, m_valid = 0, m_set_to, m_set_bad;

    function automatic int lowest_grp(input logic [2:0] r);
        for (int i = 0; i < 3; i++) if (r[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_run = 0; m_age = 0; m_g = 0; m_vec = 0;
            m_lastg = 3'b000; m_lastc = 4'd0; m_eto = 0; m_ebad = 0;
            for (int i = 0; i < 3; i++) m_stat[i] = 0;
            m_valid = 1;
        end else begin
            m_set_to = 0;
            m_set_bad = 0;
            case (m_phase)
                0: if (grp_req != 0) begin
                    m_phase = 1; m_run = 1; m_lastg = grp_req; m_lastc = chan_idx;
                end
                1: if (grp_req == 0) m_phase = 0;
                   else begin
                       if (grp_req == m_lastg && chan_idx == m_lastc) m_run++;
                       else begin m_run = 1; m_lastg = grp_req; m_lastc = chan_idx; end
                       if (m_run == SETTLE + 1) begin
                           if (m_lastc > 8) begin m_set_bad = 1; m_phase = 0; end
                           else begin
                               m_g = lowest_grp(m_lastg);
                               m_vec = 9 * m_g + int'(m_lastc);
                               m_phase = 2; m_age = 0;
                           end
                       end
                   end
                2: if (irq_ack) begin
                       m_phase = 3;
                       if (m_stat[m_g] < 65535) m_stat[m_g]++;
                   end else begin
                       m_age++;
                       if (TIMEOUT != 0 && m_age == TIMEOUT) begin m_set_to = 1; m_phase = 0; end
                   end
                3: if (irq_eoi) m_phase = 0;
                default: m_phase = 0;
            endcase
            m_eto  = m_set_to  || (m_eto  && !err_clr);
            m_ebad = m_set_bad || (m_ebad && !err_clr);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_irq", int'(irq), (m_phase == 2) ? 1 : 0);
            chk("model_vec", int'(irq_vec), m_vec);
            chk("model_in_service", int'(in_service), (m_phase == 3) ? (1 << m_g) : 0);
            chk("model_busy", int'(busy), (m_phase != 0) ? 1 : 0);
            chk("model_err_timeout", int'(err_timeout), int'(m_eto));
            chk("model_err_badidx", int'(err_badidx), int'(m_ebad));
`ifdef IRQ_DISPATCH_STATS_EN
            chk("model_stat_a", int'(stat_a), m_stat[0]);
            chk("model_stat_b", int'(stat_b), m_stat[1]);
            chk("model_stat_c", int'(stat_c), m_stat[2]);
`endif
        end
    end

    task automatic ack_eoi();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        grp_req = 3'b000;
        step(2);
        irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
        step();
    endtask

    initial begin
        int ack_pct;
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_pct;
        step(2);
        rst = 1'b0;
        chk("rst_irq", int'(irq), 0);
        chk("rst_vec", int'(irq_vec), 0);
        chk("rst_in_service", int'(in_service), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_errs", int'({err_timeout, err_badidx}), 0);
        step(2);

        // group B channel 4, stable from cycle N: irq at N+3
        grp_req = 3'b010; chan_idx = 4'd4;
        step(2);
        chk("lat_irq_early", int'(irq), 0);
        step();
        chk("lat_irq", int'(irq), 1);
        chk("lat_vec", int'(irq_vec), 13);
        step();
        grp_req = 3'b000;
        step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("ack_irq", int'(irq), 0);
        chk("ack_in_service", int'(in_service), 3'b010);
        step(3);
        irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
        chk("eoi_in_service", int'(in_service), 0);
        chk("eoi_busy", int'(busy), 0);
        chk("hold_vec", int'(irq_vec), 13);
        step(2);

        // A beats C; then C alone with channel 8
        grp_req = 3'b101; chan_idx = 4'd8;
        step(3);
        chk("prio_vec_a", int'(irq_vec), 8);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        grp_req = 3'b100; chan_idx = 4'd8;
        step(2);
        chk("svc_ignores_req", int'(in_service), 3'b001);
        irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
        step(3);
        chk("prio_vec_c", int'(irq_vec), 26);
        chk("prio_irq_c", int'(irq), 1);
        ack_eoi();
        step(2);

        // unstable channel never presents; holding it presents after three cycles
        grp_req = 3'b001;
        for (int i = 0; i < 10; i++) begin
            chan_idx = (i % 2 == 0) ? 4'd5 : 4'd3;
            step();
            chk("toggle_irq", int'(irq), 0);
        end
        chan_idx = 4'd5;
        step(2);
        chk("hold_irq_early", int'(irq), 0);
        step();
        chk("hold_irq", int'(irq), 1);
        chk("hold_vec5", int'(irq_vec), 5);
        ack_eoi();
        step(2);

        // timeout after 64 presenting cycles
        grp_req = 3'b010; chan_idx = 4'd1;
        step(3);
        chk("to_irq_start", int'(irq), 1);
        grp_req = 3'b000;
        step(63);
        chk("to_irq_last", int'(irq), 1);
        chk("to_err_not_yet", int'(err_timeout), 0);
        step();
        chk("to_irq_drop", int'(irq), 0);
        chk("to_err", int'(err_timeout), 1);
        chk("to_busy", int'(busy), 0);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("to_err_clr", int'(err_timeout), 0);
        step(2);

        // illegal channel index
        grp_req = 3'b001; chan_idx = 4'd12;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bad_no_irq", int'(irq), 0);
        end
        chk("bad_err", int'(err_badidx), 1);
        grp_req = 3'b000;
        step(2);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("bad_err_clr", int'(err_badidx), 0);

        // reset while in service
        grp_req = 3'b100; chan_idx = 4'd7;
        step(3);
        chk("pre_rst_vec", int'(irq_vec), 25);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("pre_rst_svc", int'(in_service), 3'b100);
        rst = 1'b1; step(); rst = 1'b0;
        grp_req = 3'b000;
        chk("midrst_vec", int'(irq_vec), 0);
        chk("midrst_in_service", int'(in_service), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_irq", int'(irq), 0);
        step(2);

`ifdef IRQ_DISPATCH_STATS_EN
        for (int k = 0; k < 3; k++) begin
            grp_req = 3'b100; chan_idx = 4'd2;
            step(3);
            ack_eoi();
            step();
        end
        chk("stat_c_three", int'(stat_c), 3);
`endif

        // randomized traffic checked by the model every cycle
        ack_pct = 20;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: ack_pct = 0;
                    1: ack_pct = 6;
                    default: ack_pct = 35;
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin
                grp_req = 3'($urandom_range(0, 7));
                chan_idx = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                                       : 4'($urandom_range(0, 8));
            end
            irq_ack = ($urandom_range(0, 99) < ack_pct);
            irq_eoi = ($urandom_range(0, 3) == 0);
            err_clr = ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0; err_clr = 1'b0; grp_req = 3'b000;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
